// File: rtl/alu_muldiv_iter_if.sv
// Request/response bundle between EX-stage control and the iterative RV32M mul/div unit.
interface alu_muldiv_iter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
);
  logic                     start;
  logic                     flush;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    ALUResult;

  modport master (
    output start, flush, Operation, SrcA, SrcB,
    input  busy, done, ALUResult
  );

  modport slave (
    input  start, flush, Operation, SrcA, SrcB,
    output busy, done, ALUResult
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative RV32M multiply/divide: shift-add multiplier and restoring divider sharing
// one 2W accumulator, fixed W+1 cycle latency from the accepting edge to the done pulse.
module alu_muldiv_iter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_muldiv_iter_if.slave   bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t                   state_q, state_d;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [CW-1:0]            cnt_q;
  logic [2*W-1:0]           acc_q;
  logic [W-1:0]             opnd_q;
  logic [W-1:0]             srca_q;
  logic                     neg_q, rneg_q, dz_q, ovf_q;
  logic                     done_q;
  logic [W-1:0]             res_q;

  logic                     busy;
  logic                     accept;
  logic                     sgn_a, sgn_b, a_neg, b_neg, is_div;
  logic [W-1:0]             a_abs, b_abs;
  logic [W:0]               mul_sum, div_trial, div_diff;
  logic                     div_ge;
  logic [2*W-1:0]           acc_step, prod_s;
  logic [W-1:0]             quo, rem, result;

  // Operand decode for the request presented in IDLE.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (bus.Operation)
      3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      3'b010:                 sgn_a = 1'b1;
      default:                ;
    endcase
    is_div = bus.Operation[2];
    a_neg  = sgn_a & bus.SrcA[W-1];
    b_neg  = sgn_b & bus.SrcB[W-1];
    a_abs  = a_neg ? ('0 - bus.SrcA) : bus.SrcA;
    b_abs  = b_neg ? ('0 - bus.SrcB) : bus.SrcB;
    accept = (state_q == IDLE) && bus.start && !bus.flush;
  end

  // Multiply: high half accumulates, multiplier shifts out of the low half.
  // Divide: high half is the partial remainder, quotient bits shift into the low half.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    div_ge    = ~div_diff[W];
    if (op_q[2])
      acc_step = {(div_ge ? div_diff[W-1:0] : div_trial[W-1:0]), acc_q[W-2:0], div_ge};
    else
      acc_step = {mul_sum, acc_q[W-1:1]};
  end

  always_comb begin
    prod_s = neg_q ? ('0 - acc_q) : acc_q;
    quo    = acc_q[W-1:0];
    rem    = acc_q[2*W-1:W];
    case (op_q)
      3'b000:                 result = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: result = prod_s[2*W-1:W];
      3'b100, 3'b101:         result = dz_q ? '1 : ovf_q ? srca_q : (neg_q ? ('0 - quo) : quo);
      default:                result = dz_q ? srca_q : ovf_q ? '0 : (rneg_q ? ('0 - rem) : rem);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = CALC;
        CALC:    if (cnt_q == '0) state_d = FINISH;
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      srca_q <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          op_q   <= bus.Operation;
          srca_q <= bus.SrcA;
          cnt_q  <= CW'(W - 1);
          neg_q  <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          opnd_q <= is_div ? b_abs : a_abs;
          acc_q  <= {{W{1'b0}}, (is_div ? a_abs : b_abs)};
          dz_q   <= is_div && (bus.SrcB == '0);
          ovf_q  <= is_div && sgn_b && (bus.SrcA == {1'b1, {(W-1){1'b0}}}) && (bus.SrcB == '1);
        end
        CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 1'b1;
        end
        FINISH: if (!bus.flush) begin
          res_q  <= result;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.ALUResult = res_q;
endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Randomised and directed bench for alu_muldiv_iter against a plain-arithmetic RV32M model.
module tb_alu_muldiv_iter;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [31:0] last_res;

  alu_muldiv_iter_if #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) bus ();

  alu_muldiv_iter #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Counts negedges since the accepting edge; done must land on the (W+2)th.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int n0);
    int n   = n0;
    bit got = 1'b0;
    bit gap = 1'b0;
    while (!got && n < W + 8) begin
      @(negedge clk);
      n++;
      if (bus.done) got = 1'b1;
      else if (!bus.busy) gap = 1'b1;
    end
    check_eq({tag, " latency"}, 32'(n), 32'(W + 2));
    check_eq({tag, " busy-gap"}, {31'b0, gap}, 32'h0);
    check_eq({tag, " busy@done"}, {31'b0, bus.busy}, 32'h0);
    check_eq({tag, " result"}, bus.ALUResult, exp);
    last_res = exp;
  endtask

  // Called at a negedge; operands are scrambled after acceptance since they are don't-care.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit hold);
    bus.start     = 1'b1;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.start     = 1'b0;
      bus.Operation = 3'($urandom);
      bus.SrcA      = $urandom;
      bus.SrcB      = $urandom;
    end
    wait_done(tag, ref_result(op, a, b), 0);
  endtask

  initial begin
    bit saw_done;
    checks        = 0;
    failures      = 0;
    last_res      = '0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.Operation = '0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    #1;
    check_eq("reset busy", {31'b0, bus.busy}, 32'h0);
    check_eq("reset done", {31'b0, bus.done}, 32'h0);
    check_eq("reset result", bus.ALUResult, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);
    check_eq("done one-cycle", {31'b0, bus.done}, 32'h0);
    run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 1'b0);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 1'b0);
    run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 1'b0);
    run_op("REM 5/0", 3'd6, 32'd5, 32'd0, 1'b0);
    run_op("DIV -5/0", 3'd4, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush in CALC at cycle 10, then a fresh op.
    bus.start = 1'b1; bus.Operation = 3'd4; bus.SrcA = 32'd1000; bus.SrcB = 32'd3;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    @(negedge clk);
    check_eq("flush busy", {31'b0, bus.busy}, 32'h0);
    check_eq("flush done", {31'b0, bus.done}, 32'h0);
    check_eq("flush result held", bus.ALUResult, last_res);
    @(negedge clk);
    run_op("after flush DIVU", 3'd5, 32'd1000, 32'd3, 1'b0);

    // Flush landing in FINISH must suppress done and keep the old result.
    bus.start = 1'b1; bus.Operation = 3'd0; bus.SrcA = 32'd123; bus.SrcB = 32'd456;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (W) @(posedge clk);
    #1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    check_eq("finish-flush done", {31'b0, bus.done}, 32'h0);
    check_eq("finish-flush busy", {31'b0, bus.busy}, 32'h0);
    check_eq("finish-flush result", bus.ALUResult, last_res);

    // Flush beats start at the same edge.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.flush = 1'b0;
    check_eq("flush>start busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);

    // Start pulsed while busy with different operands is ignored.
    bus.start = 1'b1; bus.Operation = 3'd5; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.Operation = 3'd0; bus.SrcA = 32'd9; bus.SrcB = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("start-while-busy", 32'd14, 6);

    // Start held high across done: ops chain with no idle gap.
    run_op("b2b 1", 3'd0, 32'd11, 32'd13, 1'b1);
    run_op("b2b 2", 3'd7, 32'd50, 32'd9, 1'b1);
    run_op("b2b 3", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);

    // Asynchronous reset mid-op.
    bus.start = 1'b1; bus.Operation = 3'd3; bus.SrcA = 32'hDEAD_BEEF; bus.SrcB = 32'h1234_5678;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check_eq("rst busy", {31'b0, bus.busy}, 32'h0);
    check_eq("rst done", {31'b0, bus.done}, 32'h0);
    check_eq("rst result", bus.ALUResult, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    saw_done = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check_eq("rst no done", {31'b0, saw_done}, 32'h0);

    // Random back-to-back traffic, every opcode.
    for (int unsigned r = 0; r < 150; r++) begin
      for (int unsigned op = 0; op < 8; op++) begin
        run_op($sformatf("rand op%0d", op), 3'(op), rnd_operand(), rnd_operand(), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
